// File: rtl/uart_serial_core.sv
// 8N1 UART core, 16x-oversampled RX; TX start bit one clock after write accept, RX byte on stop-sample edge.
// Writes are refused while TXRDY=0; a received byte arriving while RXRDY=1 and unread is dropped and flags overflow.
module uart_serial_core #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [12:0] BAUD_val,
  input  logic [7:0]  data_in,
  input  logic        wen,
  input  logic        oen,
  input  logic        rx_ser,
  output logic        tx_ser,
  output logic [7:0]  data_out,
  output logic        TXRDY,
  output logic        RXRDY,
  output logic        overflow,
  output logic        framing_err
);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  tx_state_t   tx_state;
  logic [7:0]  tx_hold;
  logic [9:0]  tx_shift;
  logic [12:0] tx_baud;
  logic [12:0] tx_div;
  logic [3:0]  tx_os;
  logic [2:0]  tx_bit;
  logic        tx_tick;
  logic        tx_bit_end;
  logic        tx_load;

  assign tx_tick    = (tx_div == tx_baud);
  assign tx_bit_end = tx_tick && (tx_os == 4'd15);
  // TXRDY=0 means the holding register is full; reload straight out of the stop bit for gapless frames.
  assign tx_load    = !TXRDY && ((tx_state == TX_IDLE) || (tx_state == TX_STOP && tx_bit_end));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state <= TX_IDLE;
      tx_hold  <= '0;
      tx_shift <= '1;
      tx_baud  <= '0;
      tx_div   <= '0;
      tx_os    <= '0;
      tx_bit   <= '0;
      tx_ser   <= 1'b1;
      TXRDY    <= 1'b1;
    end else begin
      if (!wen && TXRDY) begin
        tx_hold <= data_in;
        TXRDY   <= 1'b0;
      end
      if (tx_state != TX_IDLE) begin
        tx_div <= tx_tick ? 13'd0 : tx_div + 13'd1;
        if (tx_tick) tx_os <= tx_os + 4'd1;
      end
      if (tx_load) begin
        tx_shift <= {1'b1, tx_hold, 1'b0};
        TXRDY    <= 1'b1;
        tx_baud  <= BAUD_val;
        tx_div   <= '0;
        tx_os    <= '0;
        tx_ser   <= 1'b0;
        tx_state <= TX_START;
      end else begin
        case (tx_state)
          TX_START: if (tx_bit_end) begin
            tx_shift <= tx_shift >> 1;
            tx_ser   <= tx_shift[1];
            tx_bit   <= '0;
            tx_state <= TX_DATA;
          end
          TX_DATA: if (tx_bit_end) begin
            tx_shift <= tx_shift >> 1;
            tx_ser   <= tx_shift[1];
            tx_bit   <= tx_bit + 3'd1;
            if (tx_bit == 3'd7) tx_state <= TX_STOP;
          end
          TX_STOP: if (tx_bit_end) begin
            tx_ser   <= 1'b1;
            tx_state <= TX_IDLE;
          end
          default: tx_ser <= 1'b1;
        endcase
      end
    end
  end

  rx_state_t        rx_state;
  logic [SYNC_STAGES-1:0] rx_sync;
  logic             rx_s;
  logic             rx_prev;
  logic [12:0]      rx_baud;
  logic [12:0]      rx_div;
  logic [3:0]       rx_os;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_shift;
  logic             rx_tick;
  logic             rx_stop_pt;
  logic             frame_ok;
  logic             rd;

  assign rx_s       = rx_sync[SYNC_STAGES-1];
  assign rx_tick    = (rx_div == rx_baud);
  assign rx_stop_pt = (rx_state == RX_STOP) && rx_tick && (rx_os == 4'd15);
  assign frame_ok   = rx_stop_pt && rx_s;
  assign rd         = !oen && RXRDY;

  // Synchroniser and edge history reset low so a line already low at release never looks like a start edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_sync     <= '0;
      rx_prev     <= 1'b0;
      rx_state    <= RX_IDLE;
      rx_baud     <= '0;
      rx_div      <= '0;
      rx_os       <= '0;
      rx_bit      <= '0;
      rx_shift    <= '0;
      data_out    <= '0;
      RXRDY       <= 1'b0;
      overflow    <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      rx_sync <= {rx_sync[SYNC_STAGES-2:0], rx_ser};
      rx_prev <= rx_s;
      if (rx_state != RX_IDLE) begin
        rx_div <= rx_tick ? 13'd0 : rx_div + 13'd1;
        if (rx_tick) rx_os <= rx_os + 4'd1;
      end
      if (rd) begin
        RXRDY       <= 1'b0;
        overflow    <= 1'b0;
        framing_err <= 1'b0;
      end
      case (rx_state)
        RX_IDLE: if (rx_prev && !rx_s) begin
          rx_baud  <= BAUD_val;
          rx_div   <= '0;
          rx_os    <= '0;
          rx_state <= RX_START;
        end
        RX_START: if (rx_tick && rx_os == 4'd7) begin
          rx_os    <= '0;
          rx_bit   <= '0;
          rx_state <= rx_s ? RX_IDLE : RX_DATA;
        end
        RX_DATA: if (rx_tick && rx_os == 4'd15) begin
          rx_shift <= {rx_s, rx_shift[7:1]};
          rx_bit   <= rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_state <= RX_STOP;
        end
        default: if (rx_stop_pt) begin
          rx_state <= RX_IDLE;
          if (!rx_s) framing_err <= 1'b1;
        end
      endcase
      if (frame_ok) begin
        if (!RXRDY || rd) begin
          data_out <= rx_shift;
          RXRDY    <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_serial_core.sv
// Randomized bench for uart_serial_core: TX line checked clock by clock, RX checked through loopback and direct drive.
module tb_uart_serial_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [12:0] baud;
  logic [7:0]  data_in;
  logic        wen;
  logic        oen;
  logic        rx_drv;
  logic        loop;
  logic        rx_ser_w;
  logic        tx_ser;
  logic [7:0]  data_out;
  logic        TXRDY;
  logic        RXRDY;
  logic        overflow;
  logic        framing_err;

  int n_vec = 0;
  int n_err = 0;

  // Receiver expectation at the level of delivered frames.
  logic [7:0] m_data;
  logic       m_rxrdy;
  logic       m_ovf;
  logic       m_ferr;

  always #5 clk = ~clk;
  assign rx_ser_w = loop ? tx_ser : rx_drv;

  uart_serial_core #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .BAUD_val(baud), .data_in(data_in),
    .wen(wen), .oen(oen), .rx_ser(rx_ser_w), .tx_ser(tx_ser),
    .data_out(data_out), .TXRDY(TXRDY), .RXRDY(RXRDY),
    .overflow(overflow), .framing_err(framing_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_rx(input logic [7:0] b);
    if (!m_rxrdy) begin
      m_data  = b;
      m_rxrdy = 1'b1;
    end else begin
      m_ovf = 1'b1;
    end
  endtask

  task automatic check_rx(input string tag);
    check({tag, "_rxrdy"}, 32'(RXRDY), 32'(m_rxrdy));
    check({tag, "_data"}, 32'(data_out), 32'(m_data));
    check({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
    check({tag, "_ferr"}, 32'(framing_err), 32'(m_ferr));
  endtask

  task automatic pulse_read();
    oen = 1'b0;
    step();
    oen = 1'b1;
    if (m_rxrdy) begin
      m_rxrdy = 1'b0;
      m_ovf   = 1'b0;
      m_ferr  = 1'b0;
    end
  endtask

  // Sends one or two frames in loopback; second write lands mid-frame, a third (0xFF) hits TXRDY=0.
  task automatic run_tx(input logic [7:0] b0, input logic [7:0] b1, input bit two, input int b);
    int bt;
    int nclk;
    int w;
    logic [19:0] fr;
    baud = 13'(b);
    loop = 1'b1;
    bt   = 16 * (b + 1);
    nclk = (two ? 20 : 10) * bt;
    fr   = {1'b1, b1, 1'b0, 1'b1, b0, 1'b0};
    w    = $urandom_range(0, 100 * (b + 1));
    data_in = b0;
    wen = 1'b0;
    step();
    wen = 1'b1;
    check("tx_accept_txrdy", 32'(TXRDY), 32'd0);
    step();
    check("tx_xfer_txrdy", 32'(TXRDY), 32'd1);
    for (int i = 0; i < nclk; i++) begin
      check("tx_line", 32'(tx_ser), 32'(fr[i / bt]));
      if (two && i == w) begin
        wen = 1'b0;
        data_in = b1;
      end
      if (two && i == w + 3) begin
        wen = 1'b0;
        data_in = 8'hFF;
      end
      if (!two && i == 4) baud = 13'($urandom_range(0, 7));
      step();
      wen = 1'b1;
      if (two && i == w) check("tx_second_txrdy", 32'(TXRDY), 32'd0);
    end
    check("tx_idle_line", 32'(tx_ser), 32'd1);
    check("tx_idle_txrdy", 32'(TXRDY), 32'd1);
    baud = 13'(b);
    repeat (8) step();
    model_rx(b0);
    if (two) model_rx(b1);
    check_rx("loop");
  endtask

  task automatic drive_rx(input logic [7:0] b, input logic stop, input int bdiv);
    int bt;
    logic [9:0] fr;
    loop = 1'b0;
    baud = 13'(bdiv);
    bt   = 16 * (bdiv + 1);
    fr   = {stop, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      rx_drv = fr[k];
      repeat (bt) step();
    end
    rx_drv = 1'b1;
    repeat (bt) step();
    if (stop) model_rx(b);
    else m_ferr = 1'b1;
    check_rx(stop ? "drv" : "frame_err");
  endtask

  initial begin
    rst = 1'b0; wen = 1'b1; oen = 1'b1; loop = 1'b0; rx_drv = 1'b1;
    baud = 13'd1; data_in = 8'h00;
    m_data = 8'h00; m_rxrdy = 1'b0; m_ovf = 1'b0; m_ferr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    step();
    check("rst_tx", 32'(tx_ser), 32'd1);
    check("rst_txrdy", 32'(TXRDY), 32'd1);
    check_rx("rst");

    run_tx(8'hA5, 8'h00, 1'b0, 1);
    pulse_read();
    run_tx(8'h5A, 8'h00, 1'b0, 0);
    pulse_read();
    check_rx("read_5a");
    run_tx(8'h3C, 8'hC3, 1'b1, 1);
    pulse_read();
    run_tx(8'h11, 8'h22, 1'b1, 0);
    pulse_read();
    check_rx("ovf_clear");

    for (int it = 0; it < 10; it++) begin
      run_tx(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        pulse_read();
        check_rx("rand_read");
      end
    end

    drive_rx(8'($urandom), 1'b0, 2);
    drive_rx(8'($urandom), 1'b1, 1);

    baud = 13'd3;
    rx_drv = 1'b0;
    repeat (16) step();
    rx_drv = 1'b1;
    repeat (700) step();
    check_rx("glitch");

    if (!m_rxrdy) drive_rx(8'h96, 1'b1, 0);
    loop = 1'b1;
    baud = 13'd1;
    data_in = 8'($urandom);
    wen = 1'b0;
    step();
    wen = 1'b1;
    repeat (40) step();
    rst = 1'b0;
    #1;
    m_data = 8'h00; m_rxrdy = 1'b0; m_ovf = 1'b0; m_ferr = 1'b0;
    check("midrst_tx", 32'(tx_ser), 32'd1);
    check("midrst_txrdy", 32'(TXRDY), 32'd1);
    check_rx("midrst");
    loop = 1'b0;
    rx_drv = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    repeat (400) step();
    check_rx("low_release");
    check("low_release_tx", 32'(tx_ser), 32'd1);
    rx_drv = 1'b1;
    repeat (5) step();
    run_tx(8'($urandom), 8'($urandom), 1'b1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
